dec_issue_ctrl: RTL and testbench

- Decode/issue controller between fetch and execute in the RV32IM core.
- Accepts raw instructions over a valid/ready handshake and decodes register indices, funct fields, operand-use flags and the sign-extended immediate.
- Presents one registered issue bundle to execute and stalls issue on load-use hazards.
- Includes a skid buffer, so no combinational path exists from ex_ready to if_ready.

---
 rtl/rv32_dec_pkg.sv | 26 ++
 rtl/dec_issue_ctrl_if.sv | 39 +++
 rtl/dec_issue_ctrl_field.sv | 81 ++++++++
 rtl/dec_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_dec_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_dec_pkg.sv
// rtl/rv32_dec_pkg.sv - RV32IM opcode constants, immediate formats and register-index width.
package rv32_dec_pkg;

   localparam int REG_W = 5;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_NONE
   } imm_fmt_t;

endpackage

// File: rtl/dec_issue_ctrl_if.sv
// rtl/dec_issue_ctrl_if.sv - fetch, issue, flush and load-writeback signals of the decode/issue controller.
interface dec_issue_ctrl_if #(
   parameter int W = 32
);

   logic                            if_valid;
   logic                            if_ready;
   logic [31:0]                     if_inst;
   logic [W-1:0]                    if_pc;
   logic                            flush;

   logic                            ex_valid;
   logic                            ex_ready;
   logic [W-1:0]                    ex_pc;
   logic [6:0]                      ex_opcode;
   logic [2:0]                      ex_funct3;
   logic [6:0]                      ex_funct7;
   logic [rv32_dec_pkg::REG_W-1:0]  ex_rs1;
   logic [rv32_dec_pkg::REG_W-1:0]  ex_rs2;
   logic [rv32_dec_pkg::REG_W-1:0]  ex_rd;
   logic [W-1:0]                    ex_imm;
   logic                            ex_illegal;

   logic                            wb_valid;
   logic [rv32_dec_pkg::REG_W-1:0]  wb_rd;

   modport master (
      output if_valid, if_inst, if_pc, flush, ex_ready, wb_valid, wb_rd,
      input  if_ready, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7,
             ex_rs1, ex_rs2, ex_rd, ex_imm, ex_illegal
   );

   modport slave (
      input  if_valid, if_inst, if_pc, flush, ex_ready, wb_valid, wb_rd,
      output if_ready, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_funct7,
             ex_rs1, ex_rs2, ex_rd, ex_imm, ex_illegal
   );

endinterface

// File: rtl/dec_issue_ctrl_field.sv
// rtl/dec_issue_ctrl_field.sv - dec_field_unit: combinational RV32IM field/immediate decode.
// DEC_ILLEGAL_TRAP_EN: flag unknown opcodes as illegal instead of silently issuing them as NOPs.
module dec_field_unit
   import rv32_dec_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [31:0]      inst,
   output logic [REG_W-1:0] rs1,
   output logic [REG_W-1:0] rs2,
   output logic [REG_W-1:0] rd,
   output logic             rs1_use,
   output logic             rs2_use,
   output logic [W-1:0]     imm,
   output logic             illegal
);

   logic     known;
   logic     rd_use;
   imm_fmt_t fmt;
   logic [31:0] imm32;

   always_comb begin
      known   = 1'b1;
      rs1_use = 1'b1;
      rs2_use = 1'b0;
      rd_use  = 1'b1;
      fmt     = FMT_NONE;
      case (inst[6:0])
         LUI, AUIPC: begin
            fmt     = FMT_U;
            rs1_use = 1'b0;
         end
         JAL: begin
            fmt     = FMT_J;
            rs1_use = 1'b0;
         end
         JALR, LOAD, OP_IMM, SYSTEM: fmt = FMT_I;
         BRANCH: begin
            fmt     = FMT_B;
            rs2_use = 1'b1;
            rd_use  = 1'b0;
         end
         STORE: begin
            fmt     = FMT_S;
            rs2_use = 1'b1;
            rd_use  = 1'b0;
         end
         OP: rs2_use = 1'b1;
         default: begin
            // unknown opcodes carry no operands and no destination
            known   = 1'b0;
            rs1_use = 1'b0;
            rd_use  = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (fmt)
         FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm32 = {inst[31:12], 12'b0};
         FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = 32'b0;
      endcase
   end

   assign imm = W'($signed(imm32));
   assign rs1 = rs1_use ? inst[19:15] : '0;
   assign rs2 = rs2_use ? inst[24:20] : '0;
   assign rd  = rd_use  ? inst[11:7]  : '0;

`ifdef DEC_ILLEGAL_TRAP_EN
   assign illegal = ~known;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/dec_issue_ctrl.sv
// rtl/dec_issue_ctrl.sv - decode/issue controller: skid-buffered handshake, registered issue bundle, load-use stall.
module dec_issue_ctrl
   import rv32_dec_pkg::*;
#(
   parameter int W = 32
) (
   input logic             clk,
   input logic             rst,
   dec_issue_ctrl_if.slave bus
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_SKID  = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] skid_inst;
   logic [W-1:0] skid_pc;

   logic [31:0]      dec_inst;
   logic [W-1:0]     dec_pc;
   logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;
   logic             dec_rs1_use, dec_rs2_use, dec_illegal;
   logic [W-1:0]     dec_imm;

   logic [W-1:0]     out_pc;
   logic [6:0]       out_opcode;
   logic [2:0]       out_funct3;
   logic [6:0]       out_funct7;
   logic [REG_W-1:0] out_rs1, out_rs2, out_rd;
   logic             out_rs1_use, out_rs2_use, out_illegal;
   logic [W-1:0]     out_imm;

   logic             pend_v;
   logic [REG_W-1:0] pend_rd;
   logic             wb_hit, hazard;
   logic             accept, issue, load_out, load_skid;

   assign bus.if_ready = (state != S_SKID) & ~bus.flush;
   assign accept       = bus.if_valid & bus.if_ready;
   assign issue        = bus.ex_valid & bus.ex_ready;

   // The skid entry is always older, so it feeds the decoder whenever it is occupied.
   assign dec_inst = (state == S_SKID) ? skid_inst : bus.if_inst;
   assign dec_pc   = (state == S_SKID) ? skid_pc   : bus.if_pc;

   dec_field_unit #(.W(W)) u_field (
      .inst    (dec_inst),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .rd      (dec_rd),
      .rs1_use (dec_rs1_use),
      .rs2_use (dec_rs2_use),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: if (accept) state_nxt = S_BUSY;
         S_BUSY: begin
            if (accept & ~issue)      state_nxt = S_SKID;
            else if (issue & ~accept) state_nxt = S_EMPTY;
         end
         S_SKID:  if (issue) state_nxt = S_BUSY;
         default: state_nxt = S_EMPTY;
      endcase
      if (bus.flush) state_nxt = S_EMPTY;
   end

   assign load_skid = (state == S_BUSY) & accept & ~issue;
   assign load_out  = ~bus.flush & (((state == S_EMPTY) & accept) |
                                    ((state == S_BUSY) & accept & issue) |
                                    ((state == S_SKID) & issue));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_EMPTY;
         skid_inst   <= '0;
         skid_pc     <= '0;
         out_pc      <= '0;
         out_opcode  <= '0;
         out_funct3  <= '0;
         out_funct7  <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_rs1_use <= 1'b0;
         out_rs2_use <= 1'b0;
         out_imm     <= '0;
         out_illegal <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_skid) begin
            skid_inst <= bus.if_inst;
            skid_pc   <= bus.if_pc;
         end
         if (load_out) begin
            out_pc      <= dec_pc;
            out_opcode  <= dec_inst[6:0];
            out_funct3  <= dec_inst[14:12];
            out_funct7  <= dec_inst[31:25];
            out_rs1     <= dec_rs1;
            out_rs2     <= dec_rs2;
            out_rd      <= dec_rd;
            out_rs1_use <= dec_rs1_use;
            out_rs2_use <= dec_rs2_use;
            out_imm     <= dec_imm;
            out_illegal <= dec_illegal;
         end
      end
   end

   // pend_rd is never x0 while pend_v is set, so x0 operands cannot stall.
   assign wb_hit = bus.wb_valid & (bus.wb_rd == pend_rd);
   assign hazard = pend_v & ~wb_hit &
                   ((out_rs1_use & (out_rs1 == pend_rd)) |
                    (out_rs2_use & (out_rs2 == pend_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v  <= 1'b0;
         pend_rd <= '0;
      end else if (issue & (out_opcode == LOAD) & (out_rd != '0)) begin
         pend_v  <= 1'b1;
         pend_rd <= out_rd;
      end else if (pend_v & wb_hit) begin
         pend_v  <= 1'b0;
      end
   end

   assign bus.ex_valid   = (state != S_EMPTY) & ~hazard;
   assign bus.ex_pc      = out_pc;
   assign bus.ex_opcode  = out_opcode;
   assign bus.ex_funct3  = out_funct3;
   assign bus.ex_funct7  = out_funct7;
   assign bus.ex_rs1     = out_rs1;
   assign bus.ex_rs2     = out_rs2;
   assign bus.ex_rd      = out_rd;
   assign bus.ex_imm     = out_imm;
   assign bus.ex_illegal = out_illegal;

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// tb/tb_dec_issue_ctrl.sv - directed self-checking bench for dec_issue_ctrl.
module tb_dec_issue_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   dec_issue_ctrl_if #(.W(32)) bus ();

   dec_issue_ctrl #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef DEC_ILLEGAL_TRAP_EN
   localparam logic EXP_ILL = 1'b1;
`else
   localparam logic EXP_ILL = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } vec_t;

   vec_t vecs [0:6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      bus.if_valid = 1'b1;
      bus.if_inst  = inst;
      bus.if_pc    = pc;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst          = 1'b1;
      bus.if_valid = 1'b0;
      bus.if_inst  = '0;
      bus.if_pc    = '0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      bus.wb_valid = 1'b0;
      bus.wb_rd    = '0;

      vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd0};
      vecs[1] = '{32'hFE512E23, 32'hFFFFFFFC, 5'd0, 5'd2, 5'd5};
      vecs[2] = '{32'h123453B7, 32'h12345000, 5'd7, 5'd0, 5'd0};
      vecs[3] = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd0, 5'd1, 5'd2};
      vecs[4] = '{32'h001000EF, 32'h00000800, 5'd1, 5'd0, 5'd0};
      vecs[5] = '{32'h00528333, 32'h00000000, 5'd6, 5'd5, 5'd5};
      vecs[6] = '{32'h8001A083, 32'hFFFFF800, 5'd1, 5'd3, 5'd0};

      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("rst_pc", bus.ex_pc, 32'd0);
      check("rst_imm", bus.ex_imm, 32'd0);
      check("rst_rd", {27'b0, bus.ex_rd}, 32'd0);
      check("rst_ready", {31'b0, bus.if_ready}, 32'd1);

      // decode table, one instruction every two cycles
      for (int i = 0; i < 7; i++) begin
         send(vecs[i].inst, 32'h100 + 32'(i * 4));
         tick();
         bus.if_valid = 1'b0;
         #1;
         check($sformatf("dec%0d_valid", i), {31'b0, bus.ex_valid}, 32'd1);
         check($sformatf("dec%0d_pc", i), bus.ex_pc, 32'h100 + 32'(i * 4));
         check($sformatf("dec%0d_imm", i), bus.ex_imm, vecs[i].imm);
         check($sformatf("dec%0d_rd", i), {27'b0, bus.ex_rd}, {27'b0, vecs[i].rd});
         check($sformatf("dec%0d_rs1", i), {27'b0, bus.ex_rs1}, {27'b0, vecs[i].rs1});
         check($sformatf("dec%0d_rs2", i), {27'b0, bus.ex_rs2}, {27'b0, vecs[i].rs2});
         check($sformatf("dec%0d_opc", i), {25'b0, bus.ex_opcode}, {25'b0, vecs[i].inst[6:0]});
         tick();
      end
      #1;
      check("dec_drain", {31'b0, bus.ex_valid}, 32'd0);

      // load-use: lw x5 then add x6,x5,x5
      send(32'h00012283, 32'h200);
      tick();
      send(32'h00528333, 32'h204);
      #1;
      check("lu_lw_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("lu_lw_rd", {27'b0, bus.ex_rd}, 32'd5);
      tick();
      bus.if_valid = 1'b0;
      #1;
      check("lu_stall0", {31'b0, bus.ex_valid}, 32'd0);
      check("lu_add_pc", bus.ex_pc, 32'h204);
      tick();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd4;
      #1;
      check("lu_stall_wrongwb", {31'b0, bus.ex_valid}, 32'd0);
      tick();
      bus.wb_rd = 5'd5;
      #1;
      check("lu_release", {31'b0, bus.ex_valid}, 32'd1);
      check("lu_rs1", {27'b0, bus.ex_rs1}, 32'd5);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      check("lu_done", {31'b0, bus.ex_valid}, 32'd0);

      // back-pressure: three instructions while ex_ready is low
      bus.ex_ready = 1'b0;
      send(32'h00100093, 32'h0);
      #1;
      check("bp_rdy0", {31'b0, bus.if_ready}, 32'd1);
      tick();
      send(32'h00200113, 32'h4);
      #1;
      check("bp_rdy1", {31'b0, bus.if_ready}, 32'd1);
      tick();
      send(32'h00300193, 32'h8);
      #1;
      check("bp_rdy2", {31'b0, bus.if_ready}, 32'd0);
      check("bp_hold_pc", bus.ex_pc, 32'h0);
      tick();
      bus.ex_ready = 1'b1;
      #1;
      check("bp_out0_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("bp_out0_pc", bus.ex_pc, 32'h0);
      check("bp_rdy_skid", {31'b0, bus.if_ready}, 32'd0);
      tick();
      #1;
      check("bp_out1_pc", bus.ex_pc, 32'h4);
      check("bp_out1_imm", bus.ex_imm, 32'd2);
      check("bp_rdy_busy", {31'b0, bus.if_ready}, 32'd1);
      tick();
      bus.if_valid = 1'b0;
      #1;
      check("bp_out2_pc", bus.ex_pc, 32'h8);
      check("bp_out2_imm", bus.ex_imm, 32'd3);
      check("bp_out2_valid", {31'b0, bus.ex_valid}, 32'd1);
      tick();
      #1;
      check("bp_empty", {31'b0, bus.ex_valid}, 32'd0);

      // flush from SKID with a load still pending
      send(32'h00012283, 32'h300);
      tick();
      bus.if_valid = 1'b0;
      tick();
      bus.ex_ready = 1'b0;
      send(32'h00528333, 32'h304);
      tick();
      send(32'h00100093, 32'h308);
      tick();
      bus.if_valid = 1'b0;
      bus.flush    = 1'b1;
      #1;
      check("fl_rdy_during", {31'b0, bus.if_ready}, 32'd0);
      tick();
      bus.flush = 1'b0;
      #1;
      check("fl_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("fl_rdy", {31'b0, bus.if_ready}, 32'd1);
      bus.ex_ready = 1'b1;
      send(32'h00528333, 32'h310);
      tick();
      bus.if_valid = 1'b0;
      #1;
      check("fl_pend_kept", {31'b0, bus.ex_valid}, 32'd0);
      check("fl_new_pc", bus.ex_pc, 32'h310);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      #1;
      check("fl_wb_release", {31'b0, bus.ex_valid}, 32'd1);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      check("fl_done", {31'b0, bus.ex_valid}, 32'd0);

      // unknown opcodes
      for (int i = 0; i < 2; i++) begin
         send((i == 0) ? 32'h0000007F : 32'hFFFFFFFF, 32'h400 + 32'(i * 4));
         tick();
         bus.if_valid = 1'b0;
         #1;
         check($sformatf("ill%0d_valid", i), {31'b0, bus.ex_valid}, 32'd1);
         check($sformatf("ill%0d_flag", i), {31'b0, bus.ex_illegal}, {31'b0, EXP_ILL});
         check($sformatf("ill%0d_imm", i), bus.ex_imm, 32'd0);
         check($sformatf("ill%0d_rd", i), {27'b0, bus.ex_rd}, 32'd0);
         check($sformatf("ill%0d_rs1", i), {27'b0, bus.ex_rs1}, 32'd0);
         check($sformatf("ill%0d_rs2", i), {27'b0, bus.ex_rs2}, 32'd0);
         tick();
      end

      // reset with SKID full and a load pending
      send(32'h00012283, 32'h500);
      tick();
      bus.if_valid = 1'b0;
      tick();
      bus.ex_ready = 1'b0;
      send(32'h00100093, 32'h504);
      tick();
      send(32'h00200113, 32'h508);
      tick();
      bus.if_valid = 1'b0;
      #1;
      check("rs_skid_full", {31'b0, bus.if_ready}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rs_valid", {31'b0, bus.ex_valid}, 32'd0);
      check("rs_pc", bus.ex_pc, 32'd0);
      check("rs_imm", bus.ex_imm, 32'd0);
      check("rs_opc", {25'b0, bus.ex_opcode}, 32'd0);
      check("rs_rdy", {31'b0, bus.if_ready}, 32'd1);
      bus.ex_ready = 1'b1;
      send(32'h0002A303, 32'h600);
      tick();
      bus.if_valid = 1'b0;
      #1;
      check("rs_nostall", {31'b0, bus.ex_valid}, 32'd1);
      check("rs_new_pc", bus.ex_pc, 32'h600);
      check("rs_new_rs1", {27'b0, bus.ex_rs1}, 32'd5);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
